// File: rtl/data_pack_if.sv
// data_pack stream bundle: value input side and packed word output side.
// pkt_len_out exists only when DATA_PACK_LEN_EN is defined.
interface data_pack_if #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 32
);
  logic             ready_out;
  logic             valid_in;
  logic [IN_W-1:0]  data_in;
  logic             sop_in;
  logic             eop_in;
  logic             ready_in;
  logic             valid_out;
  logic [OUT_W-1:0] data_out;
  logic             sop_out;
  logic             eop_out;
`ifdef DATA_PACK_LEN_EN
  logic [15:0]      pkt_len_out;

  modport slave (
    input  valid_in, data_in, sop_in, eop_in, ready_in,
    output ready_out, valid_out, data_out, sop_out, eop_out,
    output pkt_len_out
  );

  modport master (
    output valid_in, data_in, sop_in, eop_in, ready_in,
    input  ready_out, valid_out, data_out, sop_out, eop_out,
    input  pkt_len_out
  );
`else
  modport slave (
    input  valid_in, data_in, sop_in, eop_in, ready_in,
    output ready_out, valid_out, data_out, sop_out, eop_out
  );

  modport master (
    output valid_in, data_in, sop_in, eop_in, ready_in,
    input  ready_out, valid_out, data_out, sop_out, eop_out
  );
`endif
endinterface

// File: rtl/data_pack.sv
// data_pack: packs IN_W-bit values LSB-first into OUT_W-bit framed words.
// Optional macro DATA_PACK_LEN_EN adds the per-packet value count output.
module data_pack #(
  parameter int IN_W  = 7,
  parameter int OUT_W = 32,
  parameter int CNT_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  data_pack_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_FLUSH
  } state_t;

  localparam logic [CNT_W-1:0] LP_OUT = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] LP_IN  = CNT_W'(IN_W);

  state_t r_state;
  state_t w_state_nx;

  logic [CNT_W-1:0] r_fill;
  logic [CNT_W-1:0] w_fill_nx;
  logic [CNT_W-1:0] w_base_fill;
  logic [CNT_W-1:0] w_nf;
  logic [OUT_W-1:0] r_res;
  logic [OUT_W-1:0] w_res_nx;
  logic [OUT_W-1:0] w_base_res;
  logic [OUT_W+IN_W-1:0] w_comb;

  logic r_sop_pend;
  logic w_sop_pend_nx;
  logic w_sop_word;

  logic             r_valid;
  logic             w_valid_nx;
  logic [OUT_W-1:0] r_data;
  logic [OUT_W-1:0] w_data_nx;
  logic             r_sop;
  logic             w_sop_nx;
  logic             r_eop;
  logic             w_eop_nx;
  logic             w_load;

  logic w_free;
  logic w_rdy;
  logic w_acc;
  logic w_proc;

  assign w_free = !r_valid || bus.ready_in;
  assign w_rdy  = (r_state != S_FLUSH) && w_free;
  assign w_acc  = bus.valid_in && w_rdy;
  // Values outside a packet are swallowed; a sop always restarts.
  assign w_proc = w_acc && (bus.sop_in || r_state == S_ACC);

  // A sop value starts from an empty accumulator, dropping any residual.
  assign w_base_fill = bus.sop_in ? '0 : r_fill;
  assign w_base_res  = bus.sop_in ? '0 : r_res;
  assign w_nf        = w_base_fill + LP_IN;
  assign w_sop_word  = r_sop_pend || bus.sop_in;

  assign w_comb = {{IN_W{1'b0}}, w_base_res}
                | ({{OUT_W{1'b0}}, bus.data_in} << w_base_fill);

  assign bus.ready_out = w_rdy;
  assign bus.valid_out = r_valid;
  assign bus.data_out  = r_data;
  assign bus.sop_out   = r_sop;
  assign bus.eop_out   = r_eop;

  // Next-state, accumulator and output-entry update.
  always_comb begin
    w_state_nx    = r_state;
    w_fill_nx     = r_fill;
    w_res_nx      = r_res;
    w_sop_pend_nx = r_sop_pend;
    w_valid_nx    = r_valid && !bus.ready_in;
    w_data_nx     = r_data;
    w_sop_nx      = r_sop;
    w_eop_nx      = r_eop;
    w_load        = 1'b0;
    unique case (r_state)
      S_FLUSH: begin
        if (w_free) begin
          w_load        = 1'b1;
          w_data_nx     = r_res;
          w_sop_nx      = r_sop_pend;
          w_eop_nx      = 1'b1;
          w_sop_pend_nx = 1'b0;
          w_fill_nx     = '0;
          w_res_nx      = '0;
          w_state_nx    = S_IDLE;
        end
      end
      default: begin
        if (w_proc) begin
          w_sop_pend_nx = w_sop_word;
          if (w_nf >= LP_OUT) begin
            w_load        = 1'b1;
            w_data_nx     = w_comb[OUT_W-1:0];
            w_sop_nx      = w_sop_word;
            w_eop_nx      = bus.eop_in && (w_nf == LP_OUT);
            w_sop_pend_nx = 1'b0;
            w_res_nx      = {{(OUT_W-IN_W){1'b0}},
                             w_comb[OUT_W+IN_W-1:OUT_W]};
            w_fill_nx     = w_nf - LP_OUT;
            if (!bus.eop_in)
              w_state_nx = S_ACC;
            else if (w_nf == LP_OUT)
              w_state_nx = S_IDLE;
            else
              w_state_nx = S_FLUSH;
          end else if (bus.eop_in) begin
            w_load        = 1'b1;
            w_data_nx     = w_comb[OUT_W-1:0];
            w_sop_nx      = w_sop_word;
            w_eop_nx      = 1'b1;
            w_sop_pend_nx = 1'b0;
            w_fill_nx     = '0;
            w_res_nx      = '0;
            w_state_nx    = S_IDLE;
          end else begin
            w_res_nx   = w_comb[OUT_W-1:0];
            w_fill_nx  = w_nf;
            w_state_nx = S_ACC;
          end
        end
      end
    endcase
    if (w_load)
      w_valid_nx = 1'b1;
  end

  // State, accumulator and single-entry output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_fill     <= '0;
      r_res      <= '0;
      r_sop_pend <= 1'b0;
      r_valid    <= 1'b0;
      r_data     <= '0;
      r_sop      <= 1'b0;
      r_eop      <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_fill     <= w_fill_nx;
      r_res      <= w_res_nx;
      r_sop_pend <= w_sop_pend_nx;
      r_valid    <= w_valid_nx;
      r_data     <= w_data_nx;
      r_sop      <= w_sop_nx;
      r_eop      <= w_eop_nx;
    end
  end

`ifdef DATA_PACK_LEN_EN
  logic [15:0] r_len;
  logic [15:0] w_len_nx;
  logic [15:0] r_len_out;
  logic [15:0] w_len_out_nx;

  assign bus.pkt_len_out = r_len_out;

  // Running value count; the eop word snapshots it, other words show 0.
  always_comb begin
    w_len_nx     = r_len;
    w_len_out_nx = r_len_out;
    if (w_proc) begin
      if (bus.sop_in)
        w_len_nx = 16'd1;
      else if (r_len != 16'hFFFF)
        w_len_nx = r_len + 16'd1;
    end
    if (w_load)
      w_len_out_nx = w_eop_nx ? w_len_nx : 16'd0;
    else if (r_valid && bus.ready_in)
      w_len_out_nx = 16'd0;
  end

  // Packet length registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_len     <= '0;
      r_len_out <= '0;
    end else begin
      r_len     <= w_len_nx;
      r_len_out <= w_len_out_nx;
    end
  end
`endif

endmodule

// File: tb/tb_data_pack.sv
// Scoreboard bench for data_pack: bit-queue reference model, random and
// directed packets, stalls, aborts and mid-packet reset.
module tb_data_pack;

  localparam int IN_W  = 7;
  localparam int OUT_W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_pack_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  data_pack #(
    .IN_W (IN_W),
    .OUT_W(OUT_W),
    .CNT_W(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [31:0] d;
    logic        s;
    logic        e;
    logic [15:0] len;
  } wd_t;

  wd_t exp_q[$];
  wd_t log_q[$];
  int  n_checks = 0;
  int  n_err    = 0;
  int  rdy_low  = 0;

  logic rand_mode = 1'b0;
  logic rdy_fix   = 1'b1;
  logic rdy_rand  = 1'b1;

  assign bus.ready_in = rand_mode ? rdy_rand : rdy_fix;

  always @(posedge clk) begin
    #1;
    rdy_rand = ($urandom_range(0, 3) != 0);
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Reference model: a packet is a plain bit queue cut into OUT_W words.
  bit m_in_pkt = 0;
  bit m_sop_p  = 0;
  bit m_bq[$];
  int m_len    = 0;

  always @(negedge clk) begin
    wd_t w;
    if (rst) begin
      exp_q.delete();
      m_bq.delete();
      m_in_pkt = 0;
      m_sop_p  = 0;
    end else if (bus.valid_in && bus.ready_out) begin
      if (bus.sop_in) begin
        m_bq.delete();
        m_in_pkt = 1;
        m_sop_p  = 1;
        m_len    = 0;
      end
      if (m_in_pkt) begin
        if (m_len < 65535) m_len++;
        for (int i = 0; i < IN_W; i++) m_bq.push_back(bus.data_in[i]);
        while (m_bq.size() >= OUT_W) begin
          w.d = '0;
          for (int i = 0; i < OUT_W; i++) w.d[i] = m_bq.pop_front();
          w.s = m_sop_p;
          w.e = 1'b0;
          w.len = 16'd0;
          m_sop_p = 0;
          exp_q.push_back(w);
        end
        if (bus.eop_in) begin
          if (m_bq.size() > 0) begin
            w.d = '0;
            for (int i = 0; i < m_bq.size(); i++) w.d[i] = m_bq[i];
            w.s = m_sop_p;
            w.e = 1'b1;
            w.len = 16'(m_len);
            m_sop_p = 0;
            exp_q.push_back(w);
          end else begin
            exp_q[exp_q.size()-1].e   = 1'b1;
            exp_q[exp_q.size()-1].len = 16'(m_len);
          end
          m_in_pkt = 0;
          m_bq.delete();
        end
      end
    end
  end

  // Monitor: every transferred word is popped against the model.
  always @(negedge clk) begin
    wd_t g;
    wd_t e;
    if (!rst && bus.valid_out && bus.ready_in) begin
      g.d = bus.data_out;
      g.s = bus.sop_out;
      g.e = bus.eop_out;
`ifdef DATA_PACK_LEN_EN
      g.len = bus.pkt_len_out;
`else
      g.len = 16'd0;
`endif
      log_q.push_back(g);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_word: got %h expected none", g.d);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", g.d, e.d);
        chk("sb_sop", 32'(g.s), 32'(e.s));
        chk("sb_eop", 32'(g.e), 32'(e.e));
`ifdef DATA_PACK_LEN_EN
        chk("sb_len", 32'(g.len), 32'(e.len));
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && !bus.ready_out) rdy_low++;
  end

  task automatic send(input logic [6:0] v, input logic s, input logic e);
    int   n;
    logic acc;
    bus.valid_in = 1'b1;
    bus.data_in  = v;
    bus.sop_in   = s;
    bus.eop_in   = e;
    n   = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = bus.ready_out;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      n_checks++;
      n_err++;
      $display("FAIL send_timeout: got no accept expected accept");
    end
    bus.valid_in = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.valid_out) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      n_err++;
      $display("FAIL drain_timeout: got %0d queued expected 0",
               exp_q.size());
    end
  endtask

  logic [31:0] t1[7];
  logic [6:0]  v;
  int          np;

  initial begin
    t1 = '{32'hF00CC05A, 32'h7D000007, 32'h00000020, 32'h0,
           32'h0, 32'h0, 32'hFE000000};
    bus.valid_in = 1'b0;
    bus.data_in  = '0;
    bus.sop_in   = 1'b0;
    bus.eop_in   = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(bus.valid_out), 32'd0);
    chk("rst_data", bus.data_out, 32'd0);
    chk("rst_sop", 32'(bus.sop_out), 32'd0);
    chk("rst_eop", 32'(bus.eop_out), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.ready_out), 32'd1);
    @(posedge clk);
    #1;

    // 1: 32 values fill exactly 7 words
    log_q.delete();
    rdy_low = 0;
    for (int i = 0; i < 32; i++) begin
      case (i)
        0:  v = 7'h5A;
        2:  v = 7'h33;
        4:  v = 7'h7F;
        8:  v = 7'h7D;
        9:  v = 7'h40;
        31: v = 7'h7F;
        default: v = 7'h00;
      endcase
      send(v, i == 0, i == 31);
    end
    drain();
    chk("t1_nwords", log_q.size(), 32'd7);
    if (log_q.size() == 7) begin
      for (int i = 0; i < 7; i++) chk("t1_word", log_q[i].d, t1[i]);
      chk("t1_sop0", 32'(log_q[0].s), 32'd1);
      chk("t1_eop6", 32'(log_q[6].e), 32'd1);
    end
    chk("t1_ready_low", rdy_low, 32'd0);

    // 2: single value packet, 1-cycle latency
    log_q.delete();
    send(7'h55, 1'b1, 1'b1);
    @(negedge clk);
    chk("t2_valid", 32'(bus.valid_out), 32'd1);
    chk("t2_data", bus.data_out, 32'h55);
    chk("t2_sopeop", {30'd0, bus.sop_out, bus.eop_out}, 32'd3);
    @(posedge clk);
    #1;
    drain();
    chk("t2_nwords", log_q.size(), 32'd1);

    // 3: straddling eop needs one flush cycle
    log_q.delete();
    rdy_low = 0;
    for (int i = 0; i < 5; i++) send(7'h7F, i == 0, i == 4);
    drain();
    chk("t3_nwords", log_q.size(), 32'd2);
    if (log_q.size() == 2) begin
      chk("t3_w0", log_q[0].d, 32'hFFFFFFFF);
      chk("t3_w0_eop", 32'(log_q[0].e), 32'd0);
      chk("t3_w1", log_q[1].d, 32'h7);
      chk("t3_w1_eop", 32'(log_q[1].e), 32'd1);
    end
    chk("t3_ready_low", rdy_low, 32'd1);

    // 4: downstream stall holds the word
    log_q.delete();
    rdy_fix = 1'b0;
    for (int i = 0; i < 5; i++) send(7'(i + 1), i == 0, 1'b0);
    bus.valid_in = 1'b1;
    bus.data_in  = 7'd6;
    bus.sop_in   = 1'b0;
    bus.eop_in   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_ready", 32'(bus.ready_out), 32'd0);
      chk("t4_hold", bus.data_out,
          32'h1 | (32'h2 << 7) | (32'h3 << 14) | (32'h4 << 21) | (32'h5 << 28));
    end
    @(posedge clk);
    #1;
    rdy_fix = 1'b1;
    send(7'd6, 1'b0, 1'b0);
    send(7'd7, 1'b0, 1'b1);
    drain();
    chk("t4_nwords", log_q.size(), 32'd2);

    // 5a: discards in idle, then a two-value packet
    log_q.delete();
    for (int i = 0; i < 3; i++) send(7'h7F, 1'b0, i == 2);
    @(negedge clk);
    chk("t5_no_out", 32'(bus.valid_out), 32'd0);
    @(posedge clk);
    #1;
    send(7'h01, 1'b1, 1'b0);
    send(7'h02, 1'b0, 1'b1);
    drain();
    chk("t5_nwords", log_q.size(), 32'd1);
    if (log_q.size() == 1) begin
      chk("t5_word", log_q[0].d, 32'h101);
      chk("t5_sopeop", {30'd0, log_q[0].s, log_q[0].e}, 32'd3);
    end

    // 5b: sop mid-packet aborts the residual
    log_q.delete();
    for (int i = 0; i < 3; i++) send(7'h7F, i == 0, 1'b0);
    send(7'h0A, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) send(7'h05, 1'b0, i == 3);
    drain();
    chk("t5b_nwords", log_q.size(), 32'd2);
    if (log_q.size() == 2) begin
      chk("t5b_w0", log_q[0].d,
          32'h0A | (32'h5 << 7) | (32'h5 << 14) | (32'h5 << 21) | (32'h5 << 28));
      chk("t5b_sop", 32'(log_q[0].s), 32'd1);
      chk("t5b_w1", log_q[1].d, 32'h0);
      chk("t5b_eop", 32'(log_q[1].e), 32'd1);
    end

    // 6: reset mid-packet with a word pending
    log_q.delete();
    rdy_fix = 1'b0;
    for (int i = 0; i < 5; i++) send(7'h7F, i == 0, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", 32'(bus.valid_out), 32'd0);
    @(posedge clk);
    #1;
    rdy_fix = 1'b1;
    send(7'h7F, 1'b1, 1'b1);
    @(negedge clk);
    chk("t6_data", bus.data_out, 32'h7F);
    chk("t6_sopeop", {30'd0, bus.sop_out, bus.eop_out}, 32'd3);
`ifdef DATA_PACK_LEN_EN
    chk("t6_len", 32'(bus.pkt_len_out), 32'd1);
`endif
    @(posedge clk);
    #1;
    drain();
    chk("t6_nwords", log_q.size(), 32'd1);

    // random packets with random backpressure
    rand_mode = 1'b1;
    for (int p = 0; p < 40; p++) begin
      if ($urandom_range(0, 3) == 0)
        send(7'($urandom), 1'b0, 1'b0);
      np = $urandom_range(1, 12);
      for (int i = 0; i < np; i++)
        send(7'($urandom),
             (i == 0) || ($urandom_range(0, 15) == 0),
             i == np - 1);
    end
    drain();
    rand_mode = 1'b0;
    chk("sb_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
